// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types and helpers for the countdown timer
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } cd_state_t;

    // Prescaler counter width; a divide-by-1 still gets a 1-bit counter.
    function automatic int presc_width(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides enabled clock cycles down to a one-cycle tick
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    generate
        if (TICK_DIV <= 1) begin : g_bypass
            logic unused_bits;
            assign unused_bits = ^{clk, resetn, clear};
            assign tick        = enable;
        end else begin : g_div
            localparam int W = presc_width(TICK_DIV);
            localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

            logic [W-1:0] cnt;

            // Counter only advances while enabled, so a pause keeps the phase.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable) begin
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                end
            end

            assign tick = enable && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable countdown timer with pause, auto-reload and expiry pulse
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX        = 99,
    parameter int TICK_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [DATA_WIDTH-1:0] count,
    output logic                  running,
    output logic                  done,
    output logic                  expired
);

    localparam logic [DATA_WIDTH-1:0] MAX_V = DATA_WIDTH'(MAX);
    localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1);

    cd_state_t             state;
    cd_state_t             state_nxt;
    logic [DATA_WIDTH-1:0] reload;
    logic [DATA_WIDTH-1:0] load_sat;
    logic                  enable;
    logic                  tick;
    logic                  terminal;
    logic                  reload_ok;
    logic                  restart;

    assign load_sat  = (load_value > MAX_V) ? MAX_V : load_value;
    // load and stop both outrank the tick, so neither can coincide with an expiry.
    assign enable    = (state == RUN) && !load && !stop;
    assign terminal  = tick && (count == ONE);
    assign reload_ok = auto_reload && (reload != '0);
    assign restart   = (state == DONE) && start && !stop && !load && (reload != '0);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .resetn(resetn),
        .enable(enable),
        .clear (load),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, PAUSE: if (!stop && start && count != '0) state_nxt = RUN;
                RUN: begin
                    if (stop) begin
                        state_nxt = PAUSE;
                    end else if (terminal && !reload_ok) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    if (restart) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        running = 1'b0;
        done    = 1'b0;
        case (state)
            RUN:     running = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= load_sat;
            reload <= load_sat;
        end else if (restart) begin
            count <= reload;
        end else if (tick) begin
            if (count == ONE) begin
                count <= reload_ok ? reload : '0;
            end else if (count > ONE) begin
                count <= count - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            expired <= 1'b0;
        end else begin
            expired <= terminal;
        end
    end

endmodule
